// File: rtl/decrement_counter.sv
// rtl/decrement_counter.sv - loadable down-counter with run/hold/abort control FSM
module decrement_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] eff;
    logic             q_le1;

    // q <= 1 means this decrement lands on zero (or q is already zero and must not wrap)
    assign q_le1 = (q[WIDTH-1:1] == '0);
    assign zero  = (q == '0);

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        eff       = load ? d : q;
        case (state)
            IDLE, DONE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    q_nxt     = eff;
                    state_nxt = (eff != '0) ? RUN : DONE;
                end else begin
                    state_nxt = IDLE;
                    if (load) begin
                        q_nxt = d;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (pause) begin
                    state_nxt = HOLD;
                end else if (q_le1) begin
                    q_nxt     = '0;
                    state_nxt = DONE;
                end else begin
                    q_nxt = q - 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!pause) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // busy/done are flops fed from next state so they line up with q and state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            busy  <= (state_nxt == RUN) || (state_nxt == HOLD);
            done  <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_decrement_counter.sv
// tb/tb_decrement_counter.sv - table and sequence checks of decrement_counter through an expectation queue
module tb_decrement_counter;

    logic        clk;
    logic        rst;
    logic [11:0] d;
    logic        load;
    logic        start;
    logic        pause;
    logic        abort;
    logic [11:0] q;
    logic        busy;
    logic        done;
    logic        zero;

    typedef struct {
        logic        load;
        logic        start;
        logic        pause;
        logic        abort;
        logic [11:0] d;
        logic [11:0] q;
        logic        busy;
        logic        done;
    } vec_t;

    typedef struct {
        logic [11:0] q;
        logic        busy;
        logic        done;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[17];

    int n_checks;
    int n_fail;
    int busy_cnt;
    int done_cnt;

    decrement_counter #(.WIDTH(12)) dut (
        .clk   (clk),
        .rst   (rst),
        .d     (d),
        .load  (load),
        .start (start),
        .pause (pause),
        .abort (abort),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue its expected result, sample #1 after the edge.
    task automatic cycle(input logic l, input logic s, input logic p, input logic a,
                         input logic [11:0] dv, input logic [11:0] eq,
                         input logic eb, input logic edn, input string tag);
        exp_t e;
        load  = l;
        start = s;
        pause = p;
        abort = a;
        d     = dv;
        sb.push_back('{q: eq, busy: eb, done: edn, zero: (eq == 12'd0)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".q"},    int'(q),    int'(e.q));
        chk({tag, ".busy"}, int'(busy), int'(e.busy));
        chk({tag, ".done"}, int'(done), int'(e.done));
        chk({tag, ".zero"}, int'(zero), int'(e.zero));
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    endtask

    task automatic idle_cycle(input logic [11:0] eq, input logic eb, input logic edn, input string tag);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 12'd0, eq, eb, edn, tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        busy_cnt = 0;
        done_cnt = 0;

        //           load  start pause abort d       exp_q   busy  done
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'd3, 12'd3, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd2, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0};
        // start with a zero value goes straight to DONE
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0};
        // load-only, start from stored q, load ignored in RUN
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'd7, 12'd7, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'd2, 12'd7, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'd9, 12'd6, 1'b1, 1'b0};
        // abort beats pause in RUN and beats start/load in IDLE
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 12'd6, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 12'd5, 12'd6, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd6, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'd1, 12'd1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1};
        // start in DONE with q = 0 and no load re-enters DONE
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0};

        rst   = 1'b1;
        d     = 12'd0;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        chk("reset.q",    int'(q),    0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.zero", int'(zero), 1);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].load, tbl[i].start, tbl[i].pause, tbl[i].abort, tbl[i].d,
                  tbl[i].q, tbl[i].busy, tbl[i].done, $sformatf("vec%0d", i));
        end

        // pause sampled on 3 edges at q=3 plus the resume edge: q sits at 3 for 4 extra cycles
        busy_cnt = 0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 12'd5, 12'd5, 1'b1, 1'b0, "s3.start");
        idle_cycle(12'd4, 1'b1, 1'b0, "s3.run");
        idle_cycle(12'd3, 1'b1, 1'b0, "s3.run");
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd3, 1'b1, 1'b0, "s3.hold");
        idle_cycle(12'd3, 1'b1, 1'b0, "s3.resume");
        idle_cycle(12'd2, 1'b1, 1'b0, "s3.run");
        idle_cycle(12'd1, 1'b1, 1'b0, "s3.run");
        idle_cycle(12'd0, 1'b0, 1'b1, "s3.done");
        idle_cycle(12'd0, 1'b0, 1'b0, "s3.idle");
        chk("s3.busy_cycles", busy_cnt, 9);

        done_cnt = 0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 12'd10, 12'd10, 1'b1, 1'b0, "s4.start");
        for (int v = 9; v >= 6; v--)
            idle_cycle(12'(v), 1'b1, 1'b0, "s4.run");
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 12'd6, 1'b0, 1'b0, "s4.abort");
        idle_cycle(12'd6, 1'b0, 1'b0, "s4.idle");
        chk("s4.no_done_after_abort", done_cnt, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 12'd6, 1'b1, 1'b0, "s4.restart");
        for (int v = 5; v >= 1; v--)
            idle_cycle(12'(v), 1'b1, 1'b0, "s4.run2");
        idle_cycle(12'd0, 1'b0, 1'b1, "s4.done");

        // DONE from s4 is active now; start full-scale countdown with load+start
        done_cnt = 0;
        busy_cnt = 0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'hFFF, 1'b1, 1'b0, "s5.start");
        for (int v = 4094; v >= 1; v--)
            idle_cycle(12'(v), 1'b1, 1'b0, "s5.run");
        idle_cycle(12'd0, 1'b0, 1'b1, "s5.done");
        chk("s5.busy_cycles", busy_cnt, 4095);
        chk("s5.done_pulses", done_cnt, 1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 12'd2, 12'd2, 1'b1, 1'b0, "s5.b2b");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'd8, 12'd1, 1'b1, 1'b0, "s5.load_in_run");
        idle_cycle(12'd0, 1'b0, 1'b1, "s5.done2");
        idle_cycle(12'd0, 1'b0, 1'b0, "s5.idle");

        cycle(1'b1, 1'b1, 1'b0, 1'b0, 12'd110, 12'd110, 1'b1, 1'b0, "s6.start");
        for (int v = 109; v >= 100; v--)
            idle_cycle(12'(v), 1'b1, 1'b0, "s6.run");
        #2;
        rst = 1'b1;
        #1;
        chk("s6.async.q",    int'(q),    0);
        chk("s6.async.busy", int'(busy), 0);
        chk("s6.async.done", int'(done), 0);
        chk("s6.async.zero", int'(zero), 1);
        @(posedge clk);
        #1;
        chk("s6.held.q",    int'(q),    0);
        chk("s6.held.done", int'(done), 0);
        rst = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 12'd2, 12'd2, 1'b1, 1'b0, "s6.first_edge");
        idle_cycle(12'd1, 1'b1, 1'b0, "s6.run");
        idle_cycle(12'd0, 1'b0, 1'b1, "s6.done");
        idle_cycle(12'd0, 1'b0, 1'b0, "s6.idle");

        chk("sb.empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
